// File: rtl/gear_add_if.sv
// gear_add_if: request/result bundle for gear_add_arbiter; req_valid/req_a/req_b/req_exact/res_ready toward the arbiter, req_ready/res_valid/res_sum/res_id/res_err/err_cnt back
interface gear_add_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_exact;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_sum;
  logic [IDW-1:0]        res_id;
  logic                  res_err;
  logic [15:0]           err_cnt;
  modport master (
    output req_valid, req_exact, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_id, res_err, err_cnt
  );
  modport slave (
    input  req_valid, req_exact, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_id, res_err, err_cnt
  );
endinterface

// File: rtl/gear_add_arbiter.sv
// gear_add_arbiter: round-robin shared GeAr adder; clk/rst plus bus (slave): one-hot req_ready grant, tagged res_* result with exact-fix option, saturating err_cnt
module gear_add_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int R     = 4,
  parameter int P     = 4
) (
  input logic      clk,
  input logic      rst,
  gear_add_if.slave bus
);
  localparam int L   = R + P;
  localparam int K   = 1 + (WIDTH - L) / R;
  localparam int IDW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, OUT = 2'd3;
  logic [1:0]       st;
  logic [IDW-1:0]   ptr, g, id, nxt;
  logic             hit, ex_q, err, mism;
  logic [WIDTH-1:0] a_q, b_q, sum, ap, ex_sum;
  logic [15:0]      cnt;
  always_comb begin
    hit = 1'b0;
    g = '0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (bus.req_valid[(int'(ptr) + j) % NREQ]) begin
        hit = 1'b1;
        g = IDW'((int'(ptr) + j) % NREQ);
      end
  end
  assign nxt = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
  assign ap[L-1:0] = a_q[L-1:0] + b_q[L-1:0];
  for (genvar i = 1; i < K; i++) begin : g_sub
    logic [L-1:0] s;
    assign s = a_q[i*R +: L] + b_q[i*R +: L];
    assign ap[P+i*R +: R] = s[L-1:P];
  end
  assign ex_sum = a_q + b_q;
  assign mism = ap != ex_sum;
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      ptr  <= '0;
      id   <= '0;
      sum  <= '0;
      err  <= 1'b0;
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      ex_q <= 1'b0;
    end else begin
      case (st)
        IDLE: if (hit) begin
          a_q  <= bus.req_a[g*WIDTH +: WIDTH];
          b_q  <= bus.req_b[g*WIDTH +: WIDTH];
          ex_q <= bus.req_exact[g];
          id   <= g;
          ptr  <= nxt;
          st   <= CALC;
        end
        CALC: begin
          err <= mism;
          cnt <= cnt + 16'(mism && cnt != 16'hFFFF);
          sum <= ap;
          st  <= (ex_q && mism) ? FIX : OUT;
        end
        FIX: begin
          sum <= ex_sum;
          st  <= OUT;
        end
        default: if (bus.res_ready) st <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = (st == IDLE && hit) ? NREQ'(1) << g : '0;
  assign bus.res_valid = st == OUT;
  assign bus.res_sum   = sum;
  assign bus.res_id    = id;
  assign bus.res_err   = err;
  assign bus.err_cnt   = cnt;
endmodule

// File: tb/tb_gear_add_arbiter.sv
// tb_gear_add_arbiter: directed and randomized checks of gear_add_arbiter against a behavioural round-robin/GeAr model
module tb_gear_add_arbiter;
  localparam int N = 4, W = 16, TR = 4, TP = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  gear_add_if #(.NREQ(N), .WIDTH(W)) bus ();
  gear_add_arbiter #(.NREQ(N), .WIDTH(W), .R(TR), .P(TP)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  int ptr_m = 0, cnt_m = 0, mode = 0, g = 0;
  logic [N-1:0] pv = '0, pe = '0;
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic drive();
    bus.req_valid = pv;
    bus.req_exact = pe;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = pa[i];
      bus.req_b[i*W +: W] = pb[i];
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask
  function automatic logic [W-1:0] gear(input logic [W-1:0] a, input logic [W-1:0] b);
    int l = TR + TP;
    int k = 1 + (W - l) / TR;
    int m = 1 << l;
    int r, s;
    r = (int'(a) % m + int'(b) % m) % m;
    for (int i = 1; i < k; i++) begin
      s = int'(a >> (i*TR)) % m + int'(b >> (i*TR)) % m;
      r += ((s >> TP) % (1 << TR)) << (TP + i*TR);
    end
    return W'(r);
  endfunction
  task automatic refill(input int r);
    pa[r] = 16'($urandom);
    pb[r] = 16'($urandom);
    pe[r] = 1'($urandom);
    pv[r] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom) : 1'b0;
  endtask
  task automatic xact(input int dly, output int gg);
    logic [W-1:0] a, b, ap, ex;
    logic e, er;
    int lat;
    if (pv == '0) begin
      pv[$urandom % N] = 1'b1;
      drive();
      #1;
    end
    gg = 0;
    for (int j = N - 1; j >= 0; j--) if (pv[(ptr_m + j) % N]) gg = (ptr_m + j) % N;
    chk("grant", 32'(bus.req_ready), 32'(1 << gg));
    a = pa[gg];
    b = pb[gg];
    e = pe[gg];
    ap = gear(a, b);
    ex = a + b;
    er = ap != ex;
    lat = (e && er) ? 3 : 2;
    if (er && cnt_m < 65535) cnt_m++;
    ptr_m = (gg + 1) % N;
    refill(gg);
    tick();
    chk("calc_ready", 32'(bus.req_ready), 0);
    chk("calc_valid", 32'(bus.res_valid), 0);
    if (lat == 3) begin
      tick();
      chk("fix_valid", 32'(bus.res_valid), 0);
    end
    tick();
    chk("res_valid", 32'(bus.res_valid), 1);
    chk("res_sum", 32'(bus.res_sum), 32'((lat == 3) ? ex : ap));
    chk("res_id", 32'(bus.res_id), 32'(gg));
    chk("res_err", 32'(bus.res_err), 32'(er));
    chk("err_cnt", 32'(bus.err_cnt), 32'(cnt_m));
    repeat (dly) begin
      tick();
      chk("hold_valid", 32'(bus.res_valid), 1);
      chk("hold_sum", 32'(bus.res_sum), 32'((lat == 3) ? ex : ap));
      chk("hold_ready", 32'(bus.req_ready), 0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("acc_valid", 32'(bus.res_valid), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr_m = 0;
    cnt_m = 0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    bus.res_ready = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_sum", 32'(bus.res_sum), 0);
    chk("rst_id", 32'(bus.res_id), 0);
    chk("rst_err", 32'(bus.res_err), 0);
    chk("rst_cnt", 32'(bus.err_cnt), 0);
    rst = 1'b0;
    pv = 4'b0010; pa[1] = 16'h1234; pb[1] = 16'h0101; pe[1] = 1'b0;
    drive(); #1;
    xact(0, g);
    chk("tp1_sum", 32'(bus.res_sum), 32'h1335);
    chk("tp1_err", 32'(bus.res_err), 0);
    chk("tp1_cnt", 32'(bus.err_cnt), 0);
    pv = 4'b0001; pa[0] = 16'h00FF; pb[0] = 16'h0001; pe[0] = 1'b0;
    drive(); #1;
    xact(0, g);
    chk("tp2_sum", 32'(bus.res_sum), 32'h0000);
    chk("tp2_err", 32'(bus.res_err), 1);
    chk("tp2_cnt", 32'(bus.err_cnt), 1);
    pv = 4'b0001; pa[0] = 16'h00FF; pb[0] = 16'h0001; pe[0] = 1'b1;
    drive(); #1;
    xact(0, g);
    chk("tp3_sum", 32'(bus.res_sum), 32'h0100);
    chk("tp3_err", 32'(bus.res_err), 1);
    chk("tp3_cnt", 32'(bus.err_cnt), 2);
    do_reset();
    mode = 1;
    for (int i = 0; i < N; i++) refill(i);
    drive(); #1;
    for (int j = 0; j < 5; j++) begin
      xact(0, g);
      chk("rr_order", 32'(g), 32'(j % N));
    end
    mode = 0;
    pv = '0;
    refill(0);
    refill(2);
    pv[0] = 1'b1;
    pv[2] = 1'b1;
    drive(); #1;
    xact(5, g);
    chk("stall_grant", 32'(g), 2);
    xact(0, g);
    chk("after_stall_grant", 32'(g), 0);
    pv = 4'b0100; pa[2] = 16'h00FF; pb[2] = 16'h0001; pe[2] = 1'b1;
    drive(); #1;
    chk("rc_grant", 32'(bus.req_ready), 32'h4);
    pv = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr_m = 0;
    cnt_m = 0;
    chk("rc_valid", 32'(bus.res_valid), 0);
    chk("rc_sum", 32'(bus.res_sum), 0);
    chk("rc_id", 32'(bus.res_id), 0);
    chk("rc_err", 32'(bus.res_err), 0);
    chk("rc_cnt", 32'(bus.err_cnt), 0);
    chk("rc_ready", 32'(bus.req_ready), 0);
    repeat (4) begin
      tick();
      chk("rc_no_stale", 32'(bus.res_valid), 0);
    end
    pv = 4'b1010; pa[1] = 16'h0011; pb[1] = 16'h0022; pe[1] = 1'b0;
    pa[3] = 16'h0033; pb[3] = 16'h0044; pe[3] = 1'b0;
    drive(); #1;
    xact(0, g);
    chk("rc_ptr", 32'(g), 1);
    mode = 2;
    for (int n = 0; n < 60; n++) xact(int'($urandom % 3), g);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
